pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_hazard_controller_if.sv | 34 +++
 rtl/pipeline_hazard_controller.sv | 90 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller signal bundle between the ID/EX pipeline stages and the sequencer.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipeline_hazard_controller_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic        ID_MulDiv;
  logic        ID_ReadHiLo;
  logic        EX_MemRead;
  logic [4:0]  EX_rt;
  logic        EX_BranchTaken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        MulDiv_Start;
  logic        MulDiv_Busy;
  logic [15:0] StallCycles;

  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_MulDiv, ID_ReadHiLo,
    output EX_MemRead, EX_rt, EX_BranchTaken,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
    input  MulDiv_Start, MulDiv_Busy, StallCycles
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_MulDiv, ID_ReadHiLo,
    input  EX_MemRead, EX_rt, EX_BranchTaken,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
    output MulDiv_Start, MulDiv_Busy, StallCycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, taken-branch flush,
// and mult/div (HI/LO) occupancy, plus a saturating stall-cycle counter.
//
// state   | meaning
// RUN     | mult/div unit idle, a mult/div in ID may start
// MD_BUSY | mult/div unit occupied, r_cnt counts remaining busy cycles
module pipeline_hazard_controller #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MULDIV_LATENCY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_stall_cnt;

  logic w_busy;
  logic w_load_use;
  logic w_md_hazard;
  logic w_flush;
  logic w_stall;
  logic w_start;

  assign w_busy      = (r_state == MD_BUSY);
  assign w_load_use  = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
                       ((hz.ID_UseRs && (hz.ID_rs == hz.EX_rt)) ||
                        (hz.ID_UseRt && (hz.ID_rt == hz.EX_rt)));
  assign w_md_hazard = w_busy && (hz.ID_MulDiv || hz.ID_ReadHiLo);
  assign w_flush     = hz.EX_BranchTaken;
  // A taken branch kills the ID instruction, so it overrides any stall or start.
  assign w_stall     = !w_flush && (w_load_use || w_md_hazard);
  assign w_start     = hz.ID_MulDiv && !w_stall && !w_flush;

  assign hz.PC_Write     = !reset && !w_stall;
  assign hz.IF_ID_Write  = !reset && !w_stall;
  assign hz.IF_ID_Flush  = !reset && w_flush;
  assign hz.ID_EX_Bubble = !reset && (w_flush || w_stall);
  assign hz.MulDiv_Start = !reset && w_start;
  assign hz.MulDiv_Busy  = !reset && w_busy;
  assign hz.StallCycles  = r_stall_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = LAT;
        end
      end
      MD_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a 4-cycle mult/div unit.
module tb_pipeline_hazard_controller;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(.MULDIV_LATENCY(4), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the five combinational pipeline controls at once.
  task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                         input logic fl, input logic bub, input logic st);
    chk({tag, ".PC_Write"},     {15'd0, hz.PC_Write},     {15'd0, pcw});
    chk({tag, ".IF_ID_Write"},  {15'd0, hz.IF_ID_Write},  {15'd0, ifw});
    chk({tag, ".IF_ID_Flush"},  {15'd0, hz.IF_ID_Flush},  {15'd0, fl});
    chk({tag, ".ID_EX_Bubble"}, {15'd0, hz.ID_EX_Bubble}, {15'd0, bub});
    chk({tag, ".MulDiv_Start"}, {15'd0, hz.MulDiv_Start}, {15'd0, st});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ID_rs = 5'd0; hz.ID_rt = 5'd0; hz.ID_UseRs = 1'b0; hz.ID_UseRt = 1'b0;
    hz.ID_MulDiv = 1'b0; hz.ID_ReadHiLo = 1'b0;
    hz.EX_MemRead = 1'b0; hz.EX_rt = 5'd0; hz.EX_BranchTaken = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    #1;
    tick();
    tick();
    chk_ctl("rst_hold", 0, 0, 0, 0, 0);
    chk("rst_hold.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);
    chk("rst_hold.Stall", hz.StallCycles, 16'd0);

    reset = 1'b0;
    #1;
    chk_ctl("idle", 1, 1, 0, 0, 0);
    chk("idle.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);

    // Load-use on rs: exactly one stalled cycle.
    hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UseRs = 1'b1;
    #1;
    chk_ctl("lu_rs", 0, 0, 0, 1, 0);
    tick();
    idle();
    #1;
    chk("lu_rs.Stall", hz.StallCycles, 16'd1);
    chk_ctl("lu_after", 1, 1, 0, 0, 0);

    // Load to $zero never stalls.
    hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd0; hz.ID_rs = 5'd0; hz.ID_UseRs = 1'b1;
    #1;
    chk_ctl("lu_r0", 1, 1, 0, 0, 0);
    tick();
    chk("lu_r0.Stall", hz.StallCycles, 16'd1);

    // Matching rs but not read: no stall; matching rt that is read: stall.
    hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UseRs = 1'b0;
    #1;
    chk_ctl("lu_nors", 1, 1, 0, 0, 0);
    hz.ID_rs = 5'd3; hz.ID_rt = 5'd8; hz.ID_UseRt = 1'b1;
    #1;
    chk_ctl("lu_rt", 0, 0, 0, 1, 0);
    tick();
    chk("lu_rt.Stall", hz.StallCycles, 16'd2);

    // mfhi while idle: no HI/LO hazard.
    idle();
    hz.ID_ReadHiLo = 1'b1;
    #1;
    chk_ctl("mfhi_idle", 1, 1, 0, 0, 0);

    // Load-use with a taken branch: flush wins, no stall counted.
    idle();
    hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UseRs = 1'b1;
    hz.EX_BranchTaken = 1'b1;
    #1;
    chk_ctl("lu_flush", 1, 1, 1, 1, 0);
    tick();
    chk("lu_flush.Stall", hz.StallCycles, 16'd2);

    // Mult killed by a taken branch never starts.
    idle();
    hz.ID_MulDiv = 1'b1; hz.EX_BranchTaken = 1'b1;
    #1;
    chk_ctl("md_flush", 1, 1, 1, 1, 0);
    tick();
    hz.EX_BranchTaken = 1'b0; hz.ID_MulDiv = 1'b0;
    #1;
    chk("md_flush.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);

    // Mult held by a load-use stall, then a single start pulse.
    hz.ID_MulDiv = 1'b1; hz.ID_UseRs = 1'b1; hz.ID_rs = 5'd9;
    hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd9;
    #1;
    chk_ctl("md_lu", 0, 0, 0, 1, 0);
    tick();
    chk("md_lu.Stall", hz.StallCycles, 16'd3);
    chk("md_lu.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);
    hz.EX_MemRead = 1'b0; hz.EX_rt = 5'd0;
    #1;
    chk_ctl("md_start", 1, 1, 0, 0, 1);
    tick();
    // mfhi now in ID for T+1..T+4 while the unit is busy.
    idle();
    hz.ID_ReadHiLo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("md_busy.Busy", {15'd0, hz.MulDiv_Busy}, 16'd1);
      chk_ctl("md_mfhi", 0, 0, 0, 1, 0);
      tick();
    end
    #1;
    chk("md_done.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);
    chk_ctl("md_release", 1, 1, 0, 0, 0);
    chk("md_done.Stall", hz.StallCycles, 16'd7);
    tick();
    chk("md_done2.Stall", hz.StallCycles, 16'd7);

    // Reset during a mult at T+2.
    idle();
    hz.ID_MulDiv = 1'b1;
    #1;
    chk_ctl("rm_start", 1, 1, 0, 0, 1);
    tick();
    hz.ID_MulDiv = 1'b0;
    #1;
    chk("rm_t1.Busy", {15'd0, hz.MulDiv_Busy}, 16'd1);
    tick();
    reset = 1'b1;
    hz.ID_ReadHiLo = 1'b1;
    #1;
    chk_ctl("rm_t2", 0, 0, 0, 0, 0);
    chk("rm_t2.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rm_t3.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);
    chk("rm_t3.Stall", hz.StallCycles, 16'd0);
    chk_ctl("rm_t3", 1, 1, 0, 0, 0);
    hz.ID_ReadHiLo = 1'b0; hz.ID_MulDiv = 1'b1;
    #1;
    chk_ctl("rm_restart", 1, 1, 0, 0, 1);
    tick();
    hz.ID_MulDiv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("rm_busy.Busy", {15'd0, hz.MulDiv_Busy}, 16'd1);
      chk_ctl("rm_busy", 1, 1, 0, 0, 0);
      tick();
    end
    chk("rm_end.Busy", {15'd0, hz.MulDiv_Busy}, 16'd0);

    // Held load-use stall drives the counter into saturation.
    hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd4; hz.ID_rt = 5'd4; hz.ID_UseRt = 1'b1;
    for (int k = 0; k < 65534; k++) tick();
    chk("sat_m1.Stall", hz.StallCycles, 16'hFFFE);
    tick();
    chk("sat.Stall", hz.StallCycles, 16'hFFFF);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_hold.Stall", hz.StallCycles, 16'hFFFF);
    chk_ctl("sat_ctl", 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
